// File: rtl/ws2812b_pixel_feeder.sv
`default_nettype none
// ============================================================================
// Module  : ws2812b_pixel_feeder
// Brief   : Scales/masks GRB pixels, loads the WS2812B driver shift register,
//           strobes transmit and holds the latch gap after each frame.
// Rev     : 1.0  initial release
// ============================================================================
module ws2812b_pixel_feeder #(
  parameter int LATCH_CYCLES   = 6000,
  parameter int BITS_PER_PIXEL = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_data,
  input  logic        in_last,
  input  logic [7:0]  brightness,
  input  logic [2:0]  chan_mask,
  output logic        serial_out,
  output logic        transmit,
  input  logic        shift,
  output logic        busy,
  output logic        frame_done
);

  localparam int          LW         = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYCLES - 1);
  localparam logic [4:0]  LAST_BIT   = 5'(BITS_PER_PIXEL - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SCALE    = 3'd1;
  localparam logic [2:0] S_SEND     = 3'd2;
  localparam logic [2:0] S_SHIFTING = 3'd3;
  localparam logic [2:0] S_LATCH    = 3'd4;

  logic [2:0]    state_q,       state_d;
  logic [23:0]   shift_q,       shift_d;
  logic [23:0]   data_q,        data_d;
  logic          last_q,        last_d;
  logic [4:0]    bit_cnt_q,     bit_cnt_d;
  logic [LW-1:0] latch_cnt_q,   latch_cnt_d;
  logic          frame_start_q, frame_start_d;
  logic [7:0]    bright_q,      bright_d;
  logic [2:0]    mask_q,        mask_d;

  logic [7:0]    bright_eff;
  logic [2:0]    mask_eff;

  // (c * (b+1)) >> 8 keeps b=255 an exact passthrough.
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b,
                                            input logic m);
    logic [15:0] p;
    p = {8'h00, c} * ({8'h00, b} + 16'd1);
    return m ? p[15:8] : 8'h00;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      shift_q       <= 24'h0;
      data_q        <= 24'h0;
      last_q        <= 1'b0;
      bit_cnt_q     <= 5'd0;
      latch_cnt_q   <= '0;
      frame_start_q <= 1'b1;
      bright_q      <= 8'hFF;
      mask_q        <= 3'b111;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      last_q        <= last_d;
      bit_cnt_q     <= bit_cnt_d;
      latch_cnt_q   <= latch_cnt_d;
      frame_start_q <= frame_start_d;
      bright_q      <= bright_d;
      mask_q        <= mask_d;
    end
  end

  // Scale settings are sampled only on the first pixel of a frame.
  assign bright_eff = frame_start_q ? brightness : bright_q;
  assign mask_eff   = frame_start_q ? chan_mask  : mask_q;

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    data_d        = data_q;
    last_d        = last_q;
    bit_cnt_d     = bit_cnt_q;
    latch_cnt_d   = latch_cnt_q;
    frame_start_d = frame_start_q;
    bright_d      = bright_q;
    mask_d        = mask_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          last_d  = in_last;
          state_d = S_SCALE;
        end
      end
      S_SCALE: begin
        if (frame_start_q) begin
          bright_d      = brightness;
          mask_d        = chan_mask;
          frame_start_d = 1'b0;
        end
        shift_d   = {scale_chan(data_q[23:16], bright_eff, mask_eff[2]),
                     scale_chan(data_q[15:8],  bright_eff, mask_eff[1]),
                     scale_chan(data_q[7:0],   bright_eff, mask_eff[0])};
        bit_cnt_d = 5'd0;
        state_d   = S_SEND;
      end
      S_SEND: begin
        state_d = S_SHIFTING;
      end
      S_SHIFTING: begin
        if (shift) begin
          shift_d   = {shift_q[22:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = last_q ? S_LATCH : S_IDLE;
          end
        end
      end
      S_LATCH: begin
        if (latch_cnt_q == LATCH_LAST) begin
          latch_cnt_d   = '0;
          frame_start_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          latch_cnt_d = latch_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = rst_n && (state_q == S_IDLE);
    transmit   = (state_q == S_SEND);
    serial_out = (state_q != S_LATCH) && shift_q[23];
    busy       = (state_q != S_IDLE);
    frame_done = (state_q == S_LATCH) && (latch_cnt_q == LATCH_LAST);
  end

endmodule
`default_nettype wire

// File: tb/tb_ws2812b_pixel_feeder.sv
`default_nettype none
// ============================================================================
// Module  : tb_ws2812b_pixel_feeder
// Brief   : Scoreboard bench: expected pixels queued at handshake, compared
//           against the bits reassembled from serial_out.
// Rev     : 1.0  initial release
// ============================================================================
module tb_ws2812b_pixel_feeder;

  localparam int LATCH = 10;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        in_last;
  logic [7:0]  brightness;
  logic [2:0]  chan_mask;
  logic        serial_out;
  logic        transmit;
  logic        shift;
  logic        busy;
  logic        frame_done;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [23:0] sb[$];

  ws2812b_pixel_feeder #(.LATCH_CYCLES(LATCH), .BITS_PER_PIXEL(24)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .brightness(brightness),
    .chan_mask(chan_mask), .serial_out(serial_out), .transmit(transmit),
    .shift(shift), .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic latch_check(input bit poke_shift);
    for (int i = 0; i < LATCH; i++) begin
      check("latch_serial", serial_out, 0);
      check("latch_ready", in_ready, 0);
      check("latch_tx", transmit, 0);
      check("latch_done", frame_done, (i == LATCH - 1));
      shift = poke_shift && (i % 2 == 1);
      tick();
    end
    shift = 1'b0;
    check("post_latch_ready", in_ready, 1);
    check("post_latch_done", frame_done, 0);
  endtask

  // abort_pulse > 0 asserts reset while that shift pulse is being driven.
  task automatic send_pixel(input logic [23:0] d, input logic l, input logic [7:0] b,
                            input logic [2:0] m, input logic [23:0] exp,
                            input bit hold_valid, input int abort_pulse);
    int          budget;
    logic [23:0] got;
    logic [23:0] want;
    brightness = b;
    chan_mask  = m;
    in_data    = d;
    in_last    = l;
    in_valid   = 1'b1;
    budget     = 0;
    while (!in_ready && budget < 50) begin
      tick();
      budget++;
    end
    if (!in_ready) begin
      check("ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    tick();
    sb.push_back(exp);
    in_valid = 1'b0;
    check("tx_scale", transmit, 0);
    tick();
    check("tx_send", transmit, 1);
    check("busy_send", busy, 1);
    tick();
    got = 24'h0;
    for (int i = 0; i < 24; i++) begin
      if (abort_pulse > 0 && i == abort_pulse - 1) begin
        shift = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_ready", in_ready, 0);
        check("rst_serial", serial_out, 0);
        check("rst_tx", transmit, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        void'(sb.pop_front());
        shift = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        return;
      end
      got[23-i] = serial_out;
      if (hold_valid && i < 23) begin
        in_valid = 1'b1;
        in_data  = ~d;
      end else begin
        in_valid = 1'b0;
      end
      shift = 1'b1;
      tick();
      shift = 1'b0;
      check("tx_quiet", transmit, 0);
      if (hold_valid && i < 23) check("ready_shifting", in_ready, 0);
    end
    in_valid = 1'b0;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      want = sb.pop_front();
      check("pixel", got, want);
    end
    if (!l) check("ready_after", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 24'h0; in_last = 1'b0;
    brightness = 8'hFF; chan_mask = 3'b111; shift = 1'b0;
    tick();
    check("reset_ready", in_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_serial", serial_out, 0);
    check("reset_tx", transmit, 0);
    check("reset_done", frame_done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_ready", in_ready, 1);

    // Frame 1: unity passthrough, then a last pixel with shifts poked during latch.
    send_pixel(24'h123456, 1'b0, 8'hFF, 3'b111, 24'h123456, 1'b1, 0);
    send_pixel(24'h00FF0F, 1'b1, 8'hFF, 3'b111, 24'h00FF0F, 1'b0, 0);
    latch_check(1'b1);

    // Frame 2: brightness 127, single-pixel frame.
    send_pixel(24'hFF8001, 1'b1, 8'd127, 3'b111, 24'h7F4000, 1'b0, 0);
    latch_check(1'b0);

    // Frame 3: red-only mask; mid-frame brightness/mask changes are ignored.
    send_pixel(24'hAABBCC, 1'b0, 8'hFF, 3'b010, 24'h00BB00, 1'b0, 0);
    send_pixel(24'h112233, 1'b1, 8'h00, 3'b111, 24'h002200, 1'b0, 0);
    latch_check(1'b0);

    // Frame 4: the new brightness of 0 now applies.
    send_pixel(24'h5A5A5A, 1'b1, 8'h00, 3'b111, 24'h000000, 1'b0, 0);
    latch_check(1'b0);

    // Stray shift pulses while idle.
    for (int i = 0; i < 4; i++) begin
      shift = 1'b1;
      tick();
      check("idle_shift_ready", in_ready, 1);
      check("idle_shift_tx", transmit, 0);
      check("idle_shift_busy", busy, 0);
    end
    shift = 1'b0;

    // Frame 5: reset mid-pixel, then a fresh frame latches new settings.
    send_pixel(24'h123456, 1'b0, 8'hFF, 3'b111, 24'h123456, 1'b0, 0);
    send_pixel(24'h654321, 1'b0, 8'h40, 3'b101, 24'h654321, 1'b0, 12);
    check("post_rst_ready", in_ready, 1);
    send_pixel(24'h808080, 1'b1, 8'h40, 3'b101, 24'h200020, 1'b0, 0);
    latch_check(1'b0);
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
